// File: rtl/arm_pkg.sv
// Shared definitions for the operand-2 encoder.
//   enc_state_t : encoder FSM states (IDLE, SEARCH)
//   ROT_STEPS   : number of rotation candidates in the ARM immediate encoding
//   IMM8_W      : width of the rotated immediate byte
//   ROT_W       : width of the rotation field
package arm_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } enc_state_t;

  localparam int ROT_STEPS = 16;
  localparam int IMM8_W    = 8;
  localparam int ROT_W     = 4;

endpackage

// File: rtl/rot_fit8.sv
// Combinational fit test for one rotation candidate.
// Rotates value_r left by 2*rot_cnt. If the result fits in the low byte,
// then ROR(imm8, 2*rot_cnt) reproduces value_r.
// Ports:
//   value_r [31:0] in  : captured constant
//   rot_cnt [3:0]  in  : rotation candidate
//   fits           out : rotated value has all-zero upper 24 bits
//   imm8 [7:0]     out : low byte of the rotated value
module rot_fit8
  import arm_pkg::*;
(
  input  logic [31:0]       value_r,
  input  logic [ROT_W-1:0]  rot_cnt,
  output logic              fits,
  output logic [IMM8_W-1:0] imm8
);

  logic [4:0]  shamt;
  logic [63:0] dbl;
  logic [31:0] rotated;

  // A left shift of the doubled word leaves the 32-bit rotate-left in the
  // upper half, so bits that wrap across bit 31 and bit 0 come for free.
  always_comb begin
    shamt   = {rot_cnt, 1'b0};
    dbl     = {value_r, value_r} << shamt;
    rotated = dbl[63:32];
    fits    = (rotated[31:IMM8_W] == '0);
    imm8    = rotated[IMM8_W-1:0];
  end

endmodule

// File: rtl/operand2_encoder.sv
// Multi-cycle encoder producing the 12-bit shift_operand field.
// Immediate mode searches rotations 0..15 in ascending order for an
// imm8/rot pair with ROR(imm8, 2*rot) == value. LDR/STR mode checks that
// value is a sign-extended 12-bit offset.
// Ports:
//   clk                in  : clock
//   rst                in  : synchronous active-high reset
//   start              in  : request strobe, sampled only while idle
//   LDR_OR_STR         in  : 1 = memory offset mode, 0 = immediate mode
//   value [31:0]       in  : constant to encode, captured on accepted start
//   busy               out : search in progress
//   done               out : one-cycle result pulse
//   found              out : value is encodable, held until next start
//   shift_operand[11:0]out : encoded field, 0 when not found
module operand2_encoder
  import arm_pkg::*;
#(
  parameter int ROT_STEPS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        LDR_OR_STR,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] shift_operand
);

  localparam logic [ROT_W-1:0] LAST_ROT = ROT_W'(ROT_STEPS - 1);

  enc_state_t        state, state_n;
  logic [ROT_W-1:0]  rot_cnt, rot_n;
  logic [31:0]       value_r;
  logic              mode_r;
  logic              capture;
  logic              done_n, found_n;
  logic [11:0]       so_n;
  logic              fits;
  logic [IMM8_W-1:0] imm8;

  // A 12-bit signed offset sign-extends through bit 11, so bits 31..11
  // must be all ones or all zeros.
  function automatic logic ldr_fits(input logic [31:0] v);
    return (&v[31:11]) | ~(|v[31:11]);
  endfunction

  rot_fit8 u_fit (
    .value_r (value_r),
    .rot_cnt (rot_cnt),
    .fits    (fits),
    .imm8    (imm8)
  );

  always_comb begin
    state_n = state;
    rot_n   = rot_cnt;
    capture = 1'b0;
    done_n  = 1'b0;
    found_n = found;
    so_n    = shift_operand;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SEARCH;
          rot_n   = '0;
          capture = 1'b1;
          found_n = 1'b0;
          so_n    = '0;
        end
      end
      SEARCH: begin
        if (mode_r) begin
          state_n = IDLE;
          done_n  = 1'b1;
          found_n = ldr_fits(value_r);
          so_n    = ldr_fits(value_r) ? value_r[11:0] : 12'h000;
        end else if (fits) begin
          state_n = IDLE;
          done_n  = 1'b1;
          found_n = 1'b1;
          so_n    = {rot_cnt, imm8};
        end else if (rot_cnt == LAST_ROT) begin
          state_n = IDLE;
          done_n  = 1'b1;
          found_n = 1'b0;
          so_n    = '0;
        end else begin
          rot_n = rot_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rot_cnt       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      shift_operand <= '0;
    end else begin
      state         <= state_n;
      rot_cnt       <= rot_n;
      busy          <= (state_n == SEARCH);
      done          <= done_n;
      found         <= found_n;
      shift_operand <= so_n;
    end
  end

  // Operand capture; only meaningful once the FSM leaves IDLE
  always_ff @(posedge clk) begin
    if (capture) begin
      value_r <= value;
      mode_r  <= LDR_OR_STR;
    end
  end

endmodule

// File: tb/tb_operand2_encoder.sv
module tb_operand2_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        LDR_OR_STR;
  logic [31:0] value;
  logic        busy, done, found;
  logic [11:0] shift_operand;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  // model state
  logic        m_busy = 1'b0, m_done = 1'b0, m_found = 1'b0;
  logic [11:0] m_so = '0;
  logic        p_found = 1'b0;
  logic [11:0] p_so = '0;
  int          m_cnt = 0;

  operand2_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .LDR_OR_STR    (LDR_OR_STR),
    .value         (value),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .shift_operand (shift_operand)
  );

  always #5 clk = ~clk;

  // Reference: encodability and latency straight from the encoding rules.
  function automatic void ref_enc(input logic mode, input logic [31:0] v,
                                  output logic f, output logic [11:0] so,
                                  output int lat);
    logic [31:0] t;
    int sv;
    f = 1'b0; so = '0;
    if (mode) begin
      lat = 1;
      sv  = $signed(v);
      if (sv >= -2048 && sv <= 2047) begin
        f  = 1'b1;
        so = v[11:0];
      end
    end else begin
      lat = 16;
      for (int r = 0; r < 16; r++) begin
        t = (r == 0) ? v : ((v << (2*r)) | (v >> (32 - 2*r)));
        if (!f && t < 32'd256) begin
          f   = 1'b1;
          so  = {r[3:0], t[7:0]};
          lat = r + 1;
        end
      end
    end
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] v, input int s);
    return (s == 0) ? v : ((v >> s) | (v << (32 - s)));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge, then compare shortly after the edge.
  always begin
    logic f; logic [11:0] so; int lat;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_done = 0; m_found = 0; m_so = '0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_done = 1; m_found = p_found; m_so = p_so;
        end
      end else if (start) begin
        ref_enc(LDR_OR_STR, value, f, so, lat);
        p_found = f; p_so = so; m_cnt = lat;
        m_busy = 1; m_found = 0; m_so = '0;
      end
    end
    #1;
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("done", {31'b0, done}, {31'b0, m_done});
    if (!m_busy) begin
      check("found", {31'b0, found}, {31'b0, m_found});
      check("shift_operand", {20'b0, shift_operand}, {20'b0, m_so});
    end
    if (done) done_seen++;
  end

  task automatic wait_done(input bit noise);
    int k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (done) break;
      if (noise) begin
        start      = 1'($urandom % 2);
        value      = $urandom;
        LDR_OR_STR = 1'($urandom % 2);
      end
    end
    start = 0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  // Call at a falling edge; returns at the falling edge inside the done cycle.
  task automatic run_op(input logic mode, input logic [31:0] v, input bit noise);
    start = 1; LDR_OR_STR = mode; value = v;
    @(negedge clk);
    start = 0;
    wait_done(noise);
  endtask

  task automatic pin(input logic mode, input logic [31:0] v,
                     input logic ef, input logic [11:0] eso, input int elat);
    logic f; logic [11:0] so; int lat;
    ref_enc(mode, v, f, so, lat);
    check("model_found", {31'b0, f}, {31'b0, ef});
    check("model_so", {20'b0, so}, {20'b0, eso});
    check("model_lat", lat, elat);
  endtask

  initial begin
    int d0;
    logic [31:0] v;
    logic mode;
    rst = 1; start = 0; LDR_OR_STR = 0; value = '0;

    // hand-computed pins for the model
    pin(0, 32'h00000000, 1, 12'h000, 1);
    pin(0, 32'hFF000000, 1, 12'h4FF, 5);
    pin(0, 32'hF000000F, 1, 12'h2FF, 3);
    pin(0, 32'h000003FC, 1, 12'hFFF, 16);
    pin(0, 32'h00000101, 0, 12'h000, 16);
    pin(1, 32'hFFFFF800, 1, 12'h800, 1);
    pin(1, 32'h00000800, 0, 12'h000, 1);
    pin(1, 32'h000007FF, 1, 12'h7FF, 1);

    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);

    // directed cases
    run_op(0, 32'h00000000, 0); @(negedge clk);
    run_op(0, 32'hFF000000, 0); @(negedge clk);
    run_op(0, 32'hF000000F, 0); @(negedge clk);
    run_op(0, 32'h000003FC, 0); @(negedge clk);
    run_op(1, 32'hFFFFF800, 0); @(negedge clk);
    run_op(1, 32'h00000800, 0); @(negedge clk);
    run_op(1, 32'h000007FF, 0); @(negedge clk);

    // start pulses during a failing search: exactly one done
    d0 = done_seen;
    start = 1; LDR_OR_STR = 0; value = 32'h00000101;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      start = 1'(i % 2); value = $urandom; LDR_OR_STR = 1'(i % 3 == 0);
      @(negedge clk);
    end
    start = 0;
    wait_done(0);
    repeat (4) @(negedge clk);
    check("single_done", done_seen - d0, 1);

    // reset while rot_cnt is 5: no done pulse
    d0 = done_seen;
    start = 1; LDR_OR_STR = 0; value = 32'h00000101;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", done_seen - d0, 0);

    // back-to-back start in the done cycle
    run_op(1, 32'hFFFFF800, 0);
    run_op(0, 32'hFF000000, 0);
    run_op(0, 32'h00000101, 0);
    @(negedge clk);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      mode = 1'($urandom % 2);
      case ($urandom % 4)
        0: v = $urandom;
        1: v = ror32({24'b0, 8'($urandom_range(0, 255))}, 2 * $urandom_range(0, 15));
        2: v = 32'($signed($urandom_range(0, 4095)) - 2048);
        default: v = ($urandom % 2) ? 32'hFFFFF800 + 32'($urandom_range(0, 3)) - 2
                                     : 32'h000007FF + 32'($urandom_range(0, 3)) - 1;
      endcase
      run_op(mode, v, ($urandom % 2) == 1);
      if ($urandom % 3 != 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand2_encoder.md
# operand2_encoder

Multi-cycle encoder that turns a 32-bit constant into the 12-bit `shift_operand` field consumed by `Val2_generator`. It runs the data-processing immediate path in reverse: it searches for `imm8` and `rot` such that `ROR(imm8, 2*rot)` equals the value. It also encodes LDR/STR signed 12-bit offsets. It sits beside the decode/ID stage and is used by the in-design constant loader and by operand-encoding self-checks.

## Interface

Parameters:
- `ROT_STEPS`, default 16: number of rotation candidates. Fixed by the ARM encoding; not intended to be overridden.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  reset. Synchronous and active-high.
- `start`  in  1  request strobe. Sampled only in IDLE.
- `LDR_OR_STR`  in  1  mode select: 1 = memory offset encoding, 0 = data-processing immediate.
- `value`  in  32  constant to encode. Captured on an accepted `start`.
- `busy`  out  1  high while a search is in progress.
- `done`  out  1  one-cycle pulse when a result is ready.
- `found`  out  1  the value is encodable. Valid while `done` is high; held until the next accepted `start`.
- `shift_operand`  out  12  encoded field. `{rot[3:0], imm8[7:0]}` in immediate mode; the signed offset in LDR/STR mode. Forced to 0 when `found` = 0. Held like `found`.

## Operation

- FSM states:
  - IDLE: `start` = 1 captures `value` and `LDR_OR_STR` into registers, clears `rot_cnt`, and moves to SEARCH.
  - SEARCH, immediate mode: each cycle tests candidate `rot_cnt`.
    - Compute `t = ROL(value_r, 2*rot_cnt)`. On a match, `imm8 = t[7:0]`.
    - Match: `t[31:8] == 0`. Then `found` = 1, `shift_operand = {rot_cnt, t[7:0]}`, pulse `done`, go to IDLE.
    - No match and `rot_cnt == 15`: `found` = 0, `shift_operand` = 0, pulse `done`, go to IDLE.
    - Otherwise: increment `rot_cnt`.
  - SEARCH, LDR/STR mode: a single cycle.
    - Encodable iff `value_r[31:11]` are all equal (sign-extension of a 12-bit value).
    - Then `shift_operand = value_r[11:0]`, `found` = 1. Otherwise `found` = 0, `shift_operand` = 0.
    - Pulse `done`, go to IDLE.
- Candidates are tested in ascending order, so the smallest `rot` always wins. The encoding is therefore canonical (value 0 → `0x000`).
- Rotation is modulo 32. Bits wrapping across bit 31/bit 0 are legal candidates.
- `start` while `busy` is ignored. The captured operands are not disturbed.
- `value`/`LDR_OR_STR` changes after capture have no effect on the running search.

## Timing

- Reset (`rst` high at a `clk` edge):
  - FSM → IDLE, `rot_cnt` = 0.
  - `busy` = 0, `done` = 0, `found` = 0, `shift_operand` = 0.
  - Reset mid-search aborts it with no `done` pulse.
- `busy` is state == SEARCH, registered. It rises the cycle after the accepted `start`.
- All outputs are registered.
- Latency, with `start` sampled at edge E0:
  - Immediate mode, match at `rot` = r: `done` rises after edge E(r+1).
  - Immediate mode, no match: `done` rises after edge E16 (worst case).
  - LDR/STR mode: `done` rises after edge E1.
- `done` is high for exactly one cycle. In that cycle the FSM is already IDLE, so a `start` in the same cycle is accepted (back-to-back throughput).
- `rst` and `start` together: reset wins.

## Structure

- Shared package `arm_pkg`, holding:
  - `enc_state_t` enum {IDLE, SEARCH}.
  - `ROT_STEPS` = 16.
  - `IMM8_W` = 8.
  - `ROT_W` = 4.
- One combinational sub-module, `rot_fit8`:
  - Inputs: `value_r`, `rot_cnt`.
  - Outputs: `fits`, `imm8`.
  - Implements the ROL and the upper-zero test.
- The top-level file holds the FSM, capture registers and output registers.

## Test plan

- Immediate `0x00000000` → `found` = 1, `shift_operand = 0x000`, `done` after E1.
- Immediate `0xFF000000` → `found` = 1, `0x4FF`, `done` after E5. Verify: `Val2_generator` with `imm` = 1 returns `0xFF000000`.
- Immediate `0xF000000F` (wrap) → `0x2FF`. Immediate `0x000003FC` → `0xFFF`, `done` after E16.
- Immediate `0x00000101` → `found` = 0, `shift_operand = 0x000`, `done` after E16. `start` pulses during the search are ignored: exactly one `done`.
- LDR/STR mode:
  - `0xFFFFF800` → `found` = 1, `0x800`, `done` after E1.
  - `0x00000800` → `found` = 0.
  - `0x000007FF` → `0x7FF`.
- Assert `rst` at `rot_cnt` = 5 during a `0x00000101` search → all outputs 0, no `done` pulse. Then a back-to-back `start` on the `done` cycle → second result is correct.
